// File: rtl/vend_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vend_pkg
// Brief    : Shared types, coin values and price lookup for vend_controller.
// Revision : 1.0
// ============================================================================
package vend_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        VEND    = 2'd1,
        CHANGE  = 2'd2
    } state_e;

    localparam int NICKEL_C  = 5;
    localparam int DIME_C    = 10;
    localparam int QUARTER_C = 25;

    localparam int MAX_ITEMS   = 16;
    localparam int MAX_W       = 16;
    localparam int PRICE_VEC_W = MAX_ITEMS * MAX_W;

    // Price vector is passed zero-extended so one function serves any item count/width.
    function automatic logic [MAX_W-1:0] price_at(
        input logic [PRICE_VEC_W-1:0] prices,
        input int                     idx,
        input int                     width
    );
        logic [PRICE_VEC_W-1:0] shifted;
        logic [MAX_W-1:0]       mask;
        shifted = prices >> (idx * width);
        mask    = MAX_W'((32'd1 << width) - 32'd1);
        return shifted[MAX_W-1:0] & mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vend_coin_accept.sv
`default_nettype none
// ============================================================================
// Module   : vend_coin_accept
// Brief    : Coin priority, credit ceiling check and reject generation.
// Revision : 1.0
// ============================================================================
module vend_coin_accept
    import vend_pkg::*;
#(
    parameter int CREDIT_W   = 7,
    parameter int MAX_CREDIT = 100
) (
    input  logic                i_nickel,
    input  logic                i_dime,
    input  logic                i_quarter,
    input  logic                i_block,
    input  logic [CREDIT_W-1:0] i_credit,
    output logic [CREDIT_W-1:0] o_credited,
    output logic                o_reject
);

    localparam logic [CREDIT_W:0] C_MAX = (CREDIT_W+1)'(MAX_CREDIT);

    logic [CREDIT_W-1:0] w_value;
    logic                w_lower;
    logic [CREDIT_W:0]   w_sum;
    logic                w_fits;

    always_comb begin
        w_value = '0;
        w_lower = 1'b0;
        if (i_quarter) begin
            w_value = CREDIT_W'(QUARTER_C);
            w_lower = i_dime | i_nickel;
        end else if (i_dime) begin
            w_value = CREDIT_W'(DIME_C);
            w_lower = i_nickel;
        end else if (i_nickel) begin
            w_value = CREDIT_W'(NICKEL_C);
        end

        w_sum  = {1'b0, i_credit} + {1'b0, w_value};
        w_fits = (w_sum <= C_MAX);

        o_credited = '0;
        o_reject   = 1'b0;
        if (i_block) begin
            o_reject = i_nickel | i_dime | i_quarter;
        end else begin
            if (w_value != '0) begin
                if (w_fits) o_credited = w_value;
                else        o_reject   = 1'b1;
            end
            if (w_lower) o_reject = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/vend_controller.sv
`default_nettype none
// ============================================================================
// Module   : vend_controller
// Brief    : Multi-item vending FSM with shared credit, refund and nickel change.
// Revision : 1.0
// ============================================================================
module vend_controller
    import vend_pkg::*;
#(
    parameter int                            NUM_ITEMS  = 4,
    parameter int                            CREDIT_W   = 7,
    parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES     = {7'd35, 7'd30, 7'd25, 7'd15},
    parameter int                            MAX_CREDIT = 100
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 nickel_in,
    input  logic                 dime_in,
    input  logic                 quarter_in,
    input  logic [NUM_ITEMS-1:0] item_sel,
    input  logic                 select,
    input  logic                 cancel,
    output logic                 dispense,
    output logic [NUM_ITEMS-1:0] item_out,
    output logic                 nickel_out,
    output logic                 coin_reject,
    output logic [CREDIT_W-1:0]  credit,
    output logic                 busy
);

    localparam logic [PRICE_VEC_W-1:0] C_PRICES_EXT = PRICE_VEC_W'(PRICES);
    localparam logic [CREDIT_W-1:0]    C_NICKEL     = CREDIT_W'(NICKEL_C);

    state_e               r_state_q,    w_state_d;
    logic [CREDIT_W-1:0]  r_credit_q,   w_credit_d;
    logic                 r_dispense_q, w_dispense_d;
    logic [NUM_ITEMS-1:0] r_item_q,     w_item_d;
    logic                 r_nickel_q,   w_nickel_d;
    logic                 r_reject_q,   w_reject_d;
    logic                 r_busy_q,     w_busy_d;

    int                   w_sel_idx;
    logic                 w_onehot;
    logic [CREDIT_W-1:0]  w_price;
    logic                 w_accept;
    logic                 w_block;
    logic [CREDIT_W-1:0]  w_credited;
    logic                 w_coin_reject;

    always_comb begin
        w_sel_idx = 0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (item_sel[i]) w_sel_idx = i;
        end
        w_onehot = (item_sel != '0) && ((item_sel & (item_sel - NUM_ITEMS'(1))) == '0);
        w_price  = CREDIT_W'(price_at(C_PRICES_EXT, w_sel_idx, CREDIT_W));
    end

    assign w_accept = (r_state_q == COLLECT) && select && !cancel && w_onehot
                      && (w_price <= r_credit_q);
    // Coins are only credited in an otherwise idle COLLECT cycle.
    assign w_block  = (r_state_q != COLLECT) || cancel || w_accept;

    vend_coin_accept #(
        .CREDIT_W   (CREDIT_W),
        .MAX_CREDIT (MAX_CREDIT)
    ) u_coin_accept (
        .i_nickel   (nickel_in),
        .i_dime     (dime_in),
        .i_quarter  (quarter_in),
        .i_block    (w_block),
        .i_credit   (r_credit_q),
        .o_credited (w_credited),
        .o_reject   (w_coin_reject)
    );

    always_comb begin
        w_state_d    = r_state_q;
        w_credit_d   = r_credit_q;
        w_dispense_d = 1'b0;
        w_item_d     = '0;
        w_nickel_d   = 1'b0;
        case (r_state_q)
            COLLECT: begin
                if (cancel) begin
                    if (r_credit_q != '0) begin
                        w_nickel_d = 1'b1;
                        w_credit_d = r_credit_q - C_NICKEL;
                        w_state_d  = CHANGE;
                    end
                end else if (w_accept) begin
                    w_dispense_d = 1'b1;
                    w_item_d     = item_sel;
                    w_credit_d   = r_credit_q - w_price;
                    w_state_d    = VEND;
                end else begin
                    w_credit_d = r_credit_q + w_credited;
                end
            end
            VEND, CHANGE: begin
                if (r_credit_q != '0) begin
                    w_nickel_d = 1'b1;
                    w_credit_d = r_credit_q - C_NICKEL;
                    w_state_d  = CHANGE;
                end else begin
                    w_state_d  = COLLECT;
                end
            end
            default: w_state_d = COLLECT;
        endcase
        w_reject_d = w_coin_reject;
        w_busy_d   = (w_state_d != COLLECT);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state_q    <= COLLECT;
            r_credit_q   <= '0;
            r_dispense_q <= 1'b0;
            r_item_q     <= '0;
            r_nickel_q   <= 1'b0;
            r_reject_q   <= 1'b0;
            r_busy_q     <= 1'b0;
        end else begin
            r_state_q    <= w_state_d;
            r_credit_q   <= w_credit_d;
            r_dispense_q <= w_dispense_d;
            r_item_q     <= w_item_d;
            r_nickel_q   <= w_nickel_d;
            r_reject_q   <= w_reject_d;
            r_busy_q     <= w_busy_d;
        end
    end

    assign dispense    = r_dispense_q;
    assign item_out    = r_item_q;
    assign nickel_out  = r_nickel_q;
    assign coin_reject = r_reject_q;
    assign credit      = r_credit_q;
    assign busy        = r_busy_q;

endmodule
`default_nettype wire

// File: tb/tb_vend_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_vend_controller
// Brief    : Scoreboard bench for vend_controller with default parameters.
// Revision : 1.0
// ============================================================================
module tb_vend_controller;

    logic       clock = 1'b0;
    logic       reset;
    logic       nickel_in, dime_in, quarter_in;
    logic [3:0] item_sel;
    logic       select, cancel;
    logic       dispense;
    logic [3:0] item_out;
    logic       nickel_out, coin_reject, busy;
    logic [6:0] credit;

    always #5 clock = ~clock;

    vend_controller dut (
        .clock       (clock),
        .reset       (reset),
        .nickel_in   (nickel_in),
        .dime_in     (dime_in),
        .quarter_in  (quarter_in),
        .item_sel    (item_sel),
        .select      (select),
        .cancel      (cancel),
        .dispense    (dispense),
        .item_out    (item_out),
        .nickel_out  (nickel_out),
        .coin_reject (coin_reject),
        .credit      (credit),
        .busy        (busy)
    );

    typedef struct packed {
        logic       disp;
        logic [3:0] item;
        logic       nick;
        logic       rej;
        logic [6:0] cr;
        logic       busy;
    } exp_t;

    exp_t sb[$];
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   nick_cnt = 0;
    int   disp_cnt = 0;
    int   m_state  = 0;
    int   m_credit = 0;
    localparam int PRICE [4] = '{15, 25, 30, 35};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference behaviour: state 0=COLLECT 1=VEND 2=CHANGE; returns next-cycle outputs.
    task automatic model(input logic mn, md, mq, input logic [3:0] ms,
                         input logic msel, mcan, mrst, output exp_t e);
        int   v;
        int   idx;
        int   ones;
        logic lower;
        e = '0;
        if (mrst) begin
            m_state  = 0;
            m_credit = 0;
        end else if (m_state == 0) begin
            ones = 0;
            idx  = 0;
            for (int i = 0; i < 4; i++) if (ms[i]) begin ones++; idx = i; end
            if (mcan) begin
                e.rej = mn | md | mq;
                if (m_credit > 0) begin e.nick = 1'b1; m_credit -= 5; m_state = 2; end
            end else if (msel && ones == 1 && PRICE[idx] <= m_credit) begin
                e.rej    = mn | md | mq;
                e.disp   = 1'b1;
                e.item   = ms;
                m_credit -= PRICE[idx];
                m_state  = 1;
            end else begin
                v     = mq ? 25 : (md ? 10 : (mn ? 5 : 0));
                lower = mq ? (md | mn) : (md ? mn : 1'b0);
                if (v > 0) begin
                    if (m_credit + v <= 100) m_credit += v;
                    else                     e.rej = 1'b1;
                end
                if (lower) e.rej = 1'b1;
            end
        end else begin
            e.rej = mn | md | mq;
            if (m_credit > 0) begin e.nick = 1'b1; m_credit -= 5; m_state = 2; end
            else m_state = 0;
        end
        e.cr   = 7'(m_credit);
        e.busy = (m_state != 0);
    endtask

    task automatic step(input logic in_n, in_d, in_q, input logic [3:0] s,
                        input logic in_sel, in_can, in_rst);
        exp_t e;
        nickel_in  = in_n;
        dime_in    = in_d;
        quarter_in = in_q;
        item_sel   = s;
        select     = in_sel;
        cancel     = in_can;
        reset      = in_rst;
        model(in_n, in_d, in_q, s, in_sel, in_can, in_rst, e);
        sb.push_back(e);
        @(posedge clock);
        #1;
        if (sb.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("dispense",    32'(dispense),    32'(e.disp));
            check("item_out",    32'(item_out),    32'(e.item));
            check("nickel_out",  32'(nickel_out),  32'(e.nick));
            check("coin_reject", 32'(coin_reject), 32'(e.rej));
            check("credit",      32'(credit),      32'(e.cr));
            check("busy",        32'(busy),        32'(e.busy));
        end
        if (nickel_out === 1'b1) nick_cnt++;
        if (dispense === 1'b1)   disp_cnt++;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(0, 0, 0, 4'b0, 0, 0, 0);
    endtask

    task automatic coin(input logic n, d, q);
        step(n, d, q, 4'b0, 0, 0, 0);
    endtask

    task automatic buy(input logic [3:0] s);
        step(0, 0, 0, s, 1, 0, 0);
    endtask

    task automatic refund();
        step(0, 0, 0, 4'b0, 0, 1, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n0;
        int d0;
        step(0, 0, 0, 4'b0, 0, 0, 1);
        step(0, 0, 0, 4'b0, 0, 0, 1);
        check("rst_credit", 32'(credit), 32'd0);
        check("rst_busy",   32'(busy),   32'd0);

        // Exact-change purchase of item0
        n0 = nick_cnt; d0 = disp_cnt;
        coin(1, 0, 0);
        coin(0, 1, 0);
        buy(4'b0001);
        check("t1_dispense", 32'(dispense), 32'd1);
        check("t1_item",     32'(item_out), 32'd1);
        idle(3);
        check("t1_disp_cnt", 32'(disp_cnt - d0), 32'd1);
        check("t1_nick_cnt", 32'(nick_cnt - n0), 32'd0);
        check("t1_credit",   32'(credit), 32'd0);

        // 35 cents for item1 leaves two nickels of change
        n0 = nick_cnt;
        coin(0, 0, 1);
        coin(0, 1, 0);
        buy(4'b0010);
        check("t2_vend_credit", 32'(credit), 32'd10);
        idle(1);
        check("t2_credit_a", 32'(credit), 32'd5);
        idle(1);
        check("t2_credit_b", 32'(credit), 32'd0);
        idle(1);
        check("t2_busy_low", 32'(busy), 32'd0);
        check("t2_nick_cnt", 32'(nick_cnt - n0), 32'd2);

        // Underfunded select, then refund
        coin(0, 1, 0);
        buy(4'b1000);
        check("t3_ignored", 32'(credit), 32'd10);
        n0 = nick_cnt;
        refund();
        idle(3);
        check("t3_nick_cnt", 32'(nick_cnt - n0), 32'd2);
        check("t3_credit",   32'(credit), 32'd0);

        // Credit ceiling and multi-coin priority
        repeat (4) coin(0, 0, 1);
        check("t4_full", 32'(credit), 32'd100);
        coin(0, 0, 1);
        check("t4_over_reject", 32'(coin_reject), 32'd1);
        check("t4_over_credit", 32'(credit), 32'd100);
        refund();
        idle(21);
        coin(1, 0, 1);
        check("t4_pair_credit", 32'(credit), 32'd25);
        check("t4_pair_reject", 32'(coin_reject), 32'd1);

        // Coin during CHANGE, non-one-hot select, cancel beats select
        buy(4'b0001);
        idle(1);
        coin(0, 1, 0);
        check("t5_change_reject", 32'(coin_reject), 32'd1);
        check("t5_change_credit", 32'(credit), 32'd0);
        idle(2);
        coin(0, 0, 1);
        d0 = disp_cnt;
        buy(4'b0011);
        check("t5_multi_sel", 32'(credit), 32'd25);
        step(0, 0, 0, 4'b0001, 1, 1, 0);
        check("t5_cancel_nick",   32'(nickel_out), 32'd1);
        check("t5_cancel_credit", 32'(credit), 32'd20);
        idle(5);
        check("t5_no_dispense", 32'(disp_cnt - d0), 32'd0);

        // Reset in the middle of a refund
        coin(0, 1, 0);
        coin(0, 1, 0);
        refund();
        idle(1);
        check("t6_second_nick", 32'(nickel_out), 32'd1);
        step(0, 0, 0, 4'b0, 0, 0, 1);
        check("t6_rst_nick",   32'(nickel_out), 32'd0);
        check("t6_rst_credit", 32'(credit), 32'd0);
        check("t6_rst_busy",   32'(busy), 32'd0);
        n0 = nick_cnt;
        idle(4);
        check("t6_no_more_nick", 32'(nick_cnt - n0), 32'd0);

        // Random traffic against the reference
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 4) == 0, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 5) == 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 99) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vend_controller.md
# vend_controller

Parametrised multi-item vending controller, successor to the fixed-price per-item vending FSM. One shared credit register serves all NUM_ITEMS products, with runtime item selection, prices set by parameter, nickel/dime/quarter acceptance, a credit ceiling, cancel/refund, and change returned as a stream of nickel pulses. Sits between the coin-mechanism/keypad front end and the product-release and change-hopper drivers.

## Interface
- NUM_ITEMS, 4, number of products (1–16)
- CREDIT_W, 7, width of credit and price values, in cents
- PRICES, {7'd35,7'd30,7'd25,7'd15}, packed NUM_ITEMS×CREDIT_W; item i price at bits [i*CREDIT_W +: CREDIT_W]; each a nonzero multiple of 5
- MAX_CREDIT, 100, credit ceiling in cents; multiple of 5, ≤ 2^CREDIT_W−1, ≥ every price
- clock  in  1  system clock, all logic on posedge
- reset  in  1  synchronous, active-high
- nickel_in / dime_in / quarter_in  in  1 each  one-cycle coin-detect pulses (5/10/25 cents)
- item_sel  in  NUM_ITEMS  one-hot product choice, sampled only with select
- select  in  1  one-cycle purchase request
- cancel  in  1  one-cycle refund request
- dispense  out  1  one-cycle product-release pulse
- item_out  out  NUM_ITEMS  one-hot released product, valid while dispense=1, else 0
- nickel_out  out  1  one pulse per 5 cents of change/refund
- coin_reject  out  1  one-cycle pulse: a presented coin was not credited
- credit  out  CREDIT_W  current unreturned credit
- busy  out  1  high in VEND and CHANGE

## Operation
- States: COLLECT (reset state), VEND, CHANGE.
- COLLECT, coins: if multiple coin inputs are high, priority is quarter > dime > nickel; only one is considered. It is credited iff credit+value ≤ MAX_CREDIT; otherwise coin_reject. Every lower-priority coin in the same cycle also causes coin_reject.
- COLLECT, cancel: takes priority over select and coins (a coin in the same cycle is rejected). credit>0 → CHANGE. credit=0 → no action.
- COLLECT, select: item_sel not exactly one-hot → ignored. Selected price > credit → ignored, credit unchanged. Otherwise → VEND, credit ← credit−price. A coin in the same cycle as an accepted select is rejected.
- VEND: lasts one cycle; dispense=1, item_out=selection. Next state is CHANGE if credit>0, else COLLECT.
- CHANGE: each cycle, nickel_out=1 and credit decrements by 5. The cycle credit reaches 0, nickel_out=0 and the FSM returns to COLLECT.
- VEND/CHANGE: all coins are rejected; select and cancel are ignored.
- Credit is always a multiple of 5, never exceeds MAX_CREDIT, and never underflows. Price comparison is unsigned at CREDIT_W bits.

## Timing
- All outputs are registered. Reset values are 0 for every output, credit=0, state=COLLECT. Reset mid-VEND/CHANGE abandons the outstanding change; no further pulses follow.
- Coin credited at edge E: credit reflects it in the cycle after E. coin_reject is high during the cycle after E.
- Select accepted at edge E: dispense/item_out/busy are high in cycle E+1, with credit already reduced. With k=change/5, nickel_out is high in cycles E+2 … E+1+k, and busy falls in cycle E+2+k. With k=0, busy falls in cycle E+2.
- Cancel at edge E with credit c: nickel_out is high in cycles E+1 … E+c/5, with busy alongside.
- Back-to-back: a new select is accepted at the first edge where the state is COLLECT.

## Structure
- Package vend_pkg holds:
  - the state enum (COLLECT/VEND/CHANGE)
  - coin value constants NICKEL_C=5, DIME_C=10, QUARTER_C=25
  - a function extracting price i from PRICES
- Sub-module vend_coin_accept handles coin priority, the ceiling check and coin_reject generation. Its output is the credited value (0/5/10/25).
- The top level holds the FSM, credit register, price mux and output registers.

## Test plan
- Defaults, nickel+dime, select item0 (15) → dispense+item_out=0001 for 1 cycle, no nickel_out, credit 0.
- Quarter+dime (35), select item1 (25) → dispense, then nickel_out for 2 consecutive cycles, credit 10→5→0, busy drops afterwards.
- Credit 10, select item3 (35) → ignored, credit stays 10. Then cancel → 2 nickel pulses, credit 0.
- Four quarters (100), then one more quarter → coin_reject, credit 100. Quarter+nickel in the same cycle at credit 0 → credit 25, coin_reject 1.
- Coin during CHANGE → coin_reject, credit not increased. Select with item_sel=0011 → ignored. Cancel and select in the same cycle → refund only, no dispense.
- Reset asserted on the 2nd nickel of a 4-nickel refund → all outputs 0 the next cycle, state COLLECT, no further nickel_out.
